// File: rtl/hack_data_mem.sv
// Hack data memory: RAM/SCREEN/KBD map with same-cycle CPU reads, a held keyboard register and a screen scan-out stream.
// CPU reads are combinational and writes land on the edge; scan-out words stay stable while pix_ready is low.
module hack_data_mem #(
  parameter int KBD_HOLD = 4,
  parameter int SCAN_EN  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [15:0] pix_data,
  output logic [12:0] pix_addr,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        bus_err
);

  localparam int CW = (KBD_HOLD > 1) ? $clog2(KBD_HOLD) : 1;

  typedef enum logic {IDLE, HOLD} kbdState_t;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } pixWord_t;

  logic [15:0] ram    [0:16383];
  logic [15:0] screen [0:8191];

  logic isRam, isScreen, isKbd, isUnmapped;

  assign isRam      = (addressM[15:14] == 2'b00);
  assign isScreen   = (addressM[15:13] == 3'b010);
  assign isKbd      = (addressM == 16'h6000);
  assign isUnmapped = !(isRam || isScreen || isKbd);

  // Keyboard register and hold FSM
  kbdState_t     kbdState;
  logic [CW-1:0] holdCnt;
  logic [15:0]   kbdReg;
  logic          kbdRdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      kbdState <= IDLE;
      holdCnt  <= '0;
      kbdReg   <= 16'h0000;
      kbdRdy   <= 1'b1;
    end else begin
      case (kbdState)
        IDLE: begin
          if (kbd_valid) begin
            kbdReg   <= kbd_data;
            holdCnt  <= CW'(KBD_HOLD - 1);
            kbdState <= HOLD;
            kbdRdy   <= 1'b0;
          end
        end
        HOLD: begin
          if (holdCnt == '0) begin
            kbdState <= IDLE;
            kbdRdy   <= 1'b1;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        default: kbdState <= IDLE;
      endcase
    end
  end

  assign kbd_ready = kbdRdy;

  always_comb begin
    inM = 16'h0000;
    if (isRam)
      inM = ram[addressM[13:0]];
    else if (isScreen)
      inM = screen[addressM[12:0]];
    else if (isKbd)
      inM = kbdReg;
  end

  // Storage is never cleared; writes are simply blocked while reset is held.
  always_ff @(posedge clk) begin
    if (reset && writeM) begin
      if (isRam)
        ram[addressM[13:0]] <= outM;
      if (isScreen)
        screen[addressM[12:0]] <= outM;
    end
  end

  logic busErr;

  always_ff @(posedge clk) begin
    if (!reset)
      busErr <= 1'b0;
    else if (isUnmapped || (writeM && isKbd))
      busErr <= 1'b1;
  end

  assign bus_err = busErr;

  // Screen scan-out: scanPtr tracks the presented word, issuePtr the word fetched next.
  logic        scanOn;
  logic [12:0] scanPtr;
  logic [12:0] issuePtr;
  logic        pixVld;
  logic        load;
  pixWord_t    pixQ;

  assign issuePtr = pixVld ? (scanPtr + 13'd1) : scanPtr;
  assign load     = scanOn && (!pixVld || pix_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      scanOn  <= 1'b0;
      scanPtr <= 13'd0;
      pixVld  <= 1'b0;
      pixQ    <= '0;
    end else begin
      scanOn <= (SCAN_EN != 0);
      if (load) begin
        pixQ.addr <= issuePtr;
        pixQ.data <= screen[issuePtr];
        pixVld    <= 1'b1;
      end
      if (pixVld && pix_ready)
        scanPtr <= scanPtr + 13'd1;
    end
  end

  assign pix_valid = pixVld && (SCAN_EN != 0);
  assign pix_addr  = pixQ.addr;
  assign pix_data  = pixQ.data;

endmodule

// File: tb/tb_hack_data_mem.sv
// Bench for hack_data_mem: memory map, keyboard hold, scan-out stream, bus errors and reset behaviour.
module tb_hack_data_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addressM, outM, inM, kbd_data, pix_data;
  logic        writeM, kbd_valid, kbd_ready, pix_valid, pix_ready, bus_err;
  logic [12:0] pix_addr;

  int errors = 0;
  int checks = 0;

  typedef struct packed { logic [15:0] addr; logic [15:0] data; } memEnt_t;
  typedef struct packed { logic [12:0] addr; logic [15:0] data; } pixEnt_t;

  memEnt_t memQ[$];
  pixEnt_t pixQ[$];

  hack_data_mem #(.KBD_HOLD(4), .SCAN_EN(1)) dut (
    .clk(clk), .reset(reset), .addressM(addressM), .outM(outM), .writeM(writeM),
    .inM(inM), .kbd_data(kbd_data), .kbd_valid(kbd_valid), .kbd_ready(kbd_ready),
    .pix_data(pix_data), .pix_addr(pix_addr), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic cpuWrite(input logic [15:0] a, input logic [15:0] d);
    writeM = 1'b1; addressM = a; outM = d;
    @(negedge clk);
    writeM = 1'b0; addressM = 16'h0000;
  endtask

  task automatic doReset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL rst_kbd_ready: got %b want 1", kbd_ready); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_pix_valid: got %b want 0", pix_valid); end
    checks++; if (pix_addr !== 13'd0) begin errors++; $display("FAIL rst_pix_addr: got %0d want 0", pix_addr); end
    checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL rst_pix_data: got %h want 0000", pix_data); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b want 0", bus_err); end
    addressM = 16'h6000; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL rst_kbd_reg: got %h want 0000", inM); end
    addressM = 16'h0000;
    reset = 1'b1;
    @(negedge clk);
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL rst_first_edge_valid: got %b want 0", pix_valid); end
    @(negedge clk);
    checks++; if (pix_valid !== 1'b1 || pix_addr !== 13'd0) begin
      errors++; $display("FAIL rst_second_edge_valid: got v=%b a=%0d want v=1 a=0", pix_valid, pix_addr); end
  endtask

  task automatic test_ram();
    memEnt_t e;
    cpuWrite(16'h0010, 16'h1234);
    addressM = 16'h0010; #1;
    checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL ram_wr_rd: got %h want 1234", inM); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_bus_err: got %b want 0", bus_err); end
    @(negedge clk);
    e.addr = 16'h0000; e.data = 16'h0001; memQ.push_back(e); cpuWrite(e.addr, e.data);
    e.addr = 16'h3FFF; e.data = 16'hC3C3; memQ.push_back(e); cpuWrite(e.addr, e.data);
    e.addr = 16'h4000; e.data = 16'h7E7E; memQ.push_back(e); cpuWrite(e.addr, e.data);
    e.addr = 16'h5FFF; e.data = 16'h9999; memQ.push_back(e); cpuWrite(e.addr, e.data);
    while (memQ.size() > 0) begin
      e = memQ.pop_front();
      addressM = e.addr; #1;
      checks++; if (inM !== e.data) begin errors++; $display("FAIL ram_boundary @%h: got %h want %h", e.addr, inM, e.data); end
      @(negedge clk);
    end
    addressM = 16'h0000;
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL ram_boundary_bus_err: got %b want 0", bus_err); end
  endtask

  task automatic test_kbd();
    int n;
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_idle_ready: got %b want 1", kbd_ready); end
    kbd_valid = 1'b1; kbd_data = 16'h0041; addressM = 16'h6000;
    @(negedge clk);
    kbd_data = 16'h0042;
    #1;
    checks++; if (inM !== 16'h0041) begin errors++; $display("FAIL kbd_load: got %h want 0041", inM); end
    for (int i = 1; i <= 4; i++) begin
      checks++; if (kbd_ready !== 1'b0) begin errors++; $display("FAIL kbd_hold_cycle%0d: got %b want 0", i, kbd_ready); end
      @(negedge clk);
    end
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL kbd_release: got %b want 1", kbd_ready); end
    kbd_valid = 1'b0; #1;
    checks++; if (inM !== 16'h0041) begin errors++; $display("FAIL kbd_ignore_0042: got %h want 0041", inM); end
    kbd_valid = 1'b1; kbd_data = 16'h0000;
    @(negedge clk);
    kbd_valid = 1'b0; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL kbd_clear: got %h want 0000", inM); end
    n = 0;
    while (!kbd_ready && n < 10) begin n++; @(negedge clk); end
    checks++; if (n != 4) begin errors++; $display("FAIL kbd_hold_len: got %0d cycles want 4", n); end
    addressM = 16'h0000;
  endtask

  task automatic test_unmapped();
    doReset();
    addressM = 16'h6000;
    repeat (2) @(negedge clk);
    addressM = 16'h0000;
    @(negedge clk);
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_kbd_read: got %b want 0", bus_err); end
    cpuWrite(16'h3000, 16'h3333);
    cpuWrite(16'h5000, 16'h5050);
    cpuWrite(16'h7000, 16'hBEEF);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unm_write_err: got %b want 1", bus_err); end
    repeat (3) @(negedge clk);
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unm_sticky: got %b want 1", bus_err); end
    addressM = 16'h3000; #1;
    checks++; if (inM !== 16'h3333) begin errors++; $display("FAIL unm_no_ram_alias: got %h want 3333", inM); end
    addressM = 16'h5000; #1;
    checks++; if (inM !== 16'h5050) begin errors++; $display("FAIL unm_no_scr_alias: got %h want 5050", inM); end
    addressM = 16'h0000;
    doReset();
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL unm_reset_clear: got %b want 0", bus_err); end
    addressM = 16'h8000; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL unm_read_data: got %h want 0000", inM); end
    @(negedge clk);
    addressM = 16'h0000;
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unm_read_err: got %b want 1", bus_err); end
    doReset();
    addressM = 16'h6001;
    @(negedge clk);
    addressM = 16'h0000;
    checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL unm_6001_err: got %b want 1", bus_err); end
  endtask

  task automatic test_scan_wrap();
    int n;
    pix_ready = 1'b0;
    doReset();
    cpuWrite(16'h5FFF, 16'hAAAA);
    cpuWrite(16'h4000, 16'h5555);
    checks++; if (pix_data !== 16'h7E7E || pix_addr !== 13'd0) begin
      errors++; $display("FAIL scan_stall_hold: got a=%0d d=%h want a=0 d=7e7e", pix_addr, pix_data); end
    pix_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 16) begin
        checks++; if (pix_valid !== 1'b1 || pix_addr !== 13'(n)) begin
          errors++; $display("FAIL scan_back_to_back: got v=%b a=%0d want v=1 a=%0d", pix_valid, pix_addr, n); end
      end
    end while (pix_addr != 13'd8191 && n < 9000);
    pix_ready = 1'b0;
    checks++; if (pix_addr !== 13'd8191) begin errors++; $display("FAIL scan_reach_8191: got %0d want 8191", pix_addr); end
    cpuWrite(16'h5FFF, 16'h1111);
    repeat (2) @(negedge clk);
    checks++; if (pix_valid !== 1'b1 || pix_addr !== 13'd8191 || pix_data !== 16'hAAAA) begin
      errors++; $display("FAIL scan_backpressure: got v=%b a=%0d d=%h want v=1 a=8191 d=aaaa", pix_valid, pix_addr, pix_data); end
    pix_ready = 1'b1;
    @(negedge clk);
    pix_ready = 1'b0;
    checks++; if (pix_addr !== 13'd0 || pix_data !== 16'h5555) begin
      errors++; $display("FAIL scan_wrap: got a=%0d d=%h want a=0 d=5555", pix_addr, pix_data); end
  endtask

  task automatic test_collision();
    pixEnt_t p;
    int n;
    pix_ready = 1'b0;
    doReset();
    cpuWrite(16'h4005, 16'h0F0F);
    for (int i = 0; i < 8; i++) begin
      p.addr = 13'(256 + i); p.data = 16'(i * 16'h0101) ^ 16'h8000;
      pixQ.push_back(p);
      cpuWrite(16'h4000 + 16'(p.addr), p.data);
    end
    pix_ready = 1'b1;
    n = 0;
    while (pix_addr != 13'd4 && n < 20) begin @(negedge clk); n++; end
    writeM = 1'b1; addressM = 16'h4005; outM = 16'hFFFF;
    p.addr = 13'd5; p.data = 16'hFFFF; pixQ.push_back(p);
    @(negedge clk);
    writeM = 1'b0; addressM = 16'h0000;
    checks++; if (pix_addr !== 13'd5 || pix_data !== 16'h0F0F) begin
      errors++; $display("FAIL collision_old: got a=%0d d=%h want a=5 d=0f0f", pix_addr, pix_data); end
    n = 0;
    while (pixQ.size() > 0 && n < 9000) begin
      @(negedge clk);
      n++;
      if (pix_valid && pix_addr == pixQ[0].addr) begin
        p = pixQ.pop_front();
        checks++; if (pix_data !== p.data) begin
          errors++; $display("FAIL frame_pass @%0d: got %h want %h", p.addr, pix_data, p.data); end
      end
    end
    checks++; if (pixQ.size() != 0) begin
      errors++; $display("FAIL frame_pass_timeout: got %0d pending want 0", pixQ.size()); end
    pix_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    kbd_valid = 1'b1; kbd_data = 16'h0055;
    @(negedge clk);
    kbd_valid = 1'b0;
    checks++; if (kbd_ready !== 1'b0 || pix_valid !== 1'b1) begin
      errors++; $display("FAIL mid_setup: got rdy=%b v=%b want rdy=0 v=1", kbd_ready, pix_valid); end
    reset = 1'b0; writeM = 1'b1; addressM = 16'h0010; outM = 16'hDEAD;
    @(negedge clk);
    checks++; if (kbd_ready !== 1'b1) begin errors++; $display("FAIL mid_kbd_ready: got %b want 1", kbd_ready); end
    checks++; if (pix_valid !== 1'b0 || pix_addr !== 13'd0) begin
      errors++; $display("FAIL mid_pix: got v=%b a=%0d want v=0 a=0", pix_valid, pix_addr); end
    writeM = 1'b0; addressM = 16'h6000; #1;
    checks++; if (inM !== 16'h0000) begin errors++; $display("FAIL mid_kbd_reg: got %h want 0000", inM); end
    @(negedge clk);
    reset = 1'b1; addressM = 16'h0010;
    @(negedge clk);
    checks++; if (inM !== 16'h1234) begin errors++; $display("FAIL mid_ram_kept: got %h want 1234", inM); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL mid_bus_err: got %b want 0", bus_err); end
    addressM = 16'h0000;
  endtask

  initial begin
    reset = 1'b0; addressM = 16'h0000; outM = 16'h0000; writeM = 1'b0;
    kbd_data = 16'h0000; kbd_valid = 1'b0; pix_ready = 1'b0;
    test_reset();
    test_ram();
    test_kbd();
    test_unmapped();
    test_scan_wrap();
    test_collision();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
